// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  enc_pkg : shared constants and types for the binder-pack encoding slice
//  Revision: 1.0
// ============================================================================
package enc_pkg;
    localparam int N_PACKS   = 50;
    localparam int PACK_SIZE = 10;
    localparam int BIND_LAT  = 1;
    localparam int CNT_W     = 16;
    localparam int N_FEATURES = N_PACKS * PACK_SIZE;
    localparam int PIDX_W    = (N_PACKS > 1) ? $clog2(N_PACKS) : 1;

    typedef logic [PIDX_W-1:0] pack_idx_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FIRE = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } seq_state_t;
endpackage
`default_nettype wire

// File: rtl/enc_binder_pack_sequencer.sv
`default_nettype none
// ============================================================================
//  enc_binder_pack_sequencer : fires each binder pack, waits its latency and
//  hands the pack to the bundler over a valid/ready handshake.
//  Revision: 1.0
// ============================================================================
module enc_binder_pack_sequencer #(
    parameter int N_PACKS  = enc_pkg::N_PACKS,
    parameter int BIND_LAT = enc_pkg::BIND_LAT,
    parameter int CNT_W    = enc_pkg::CNT_W,
    localparam int IW      = (N_PACKS > 1) ? $clog2(N_PACKS) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               abort,
    output logic [N_PACKS-1:0] pack_start,
    output logic [IW-1:0]      pack_idx,
    output logic               pack_valid,
    input  logic               pack_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt
);
    import enc_pkg::*;

    localparam int LW = (BIND_LAT > 1) ? $clog2(BIND_LAT + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_PACKS - 1);

    seq_state_t    state;
    logic [LW-1:0] lat_cnt;

    // All outputs are registered and updated together with the state they
    // belong to, so pack_start/pack_valid/done never glitch.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            pack_start <= '0;
            pack_idx   <= '0;
            pack_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_cnt   <= '0;
        end else begin
            pack_start <= '0;
            done       <= 1'b0;
            if (abort && state != IDLE) begin
                state      <= IDLE;
                pack_idx   <= '0;
                pack_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state      <= FIRE;
                            pack_idx   <= '0;
                            pack_start <= N_PACKS'(1);
                            busy       <= 1'b1;
                        end
                    end
                    FIRE: begin
                        lat_cnt <= LW'(BIND_LAT);
                        if (BIND_LAT == 0) begin
                            state      <= EMIT;
                            pack_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (lat_cnt <= LW'(1)) begin
                            state      <= EMIT;
                            pack_valid <= 1'b1;
                        end else begin
                            lat_cnt <= lat_cnt - LW'(1);
                        end
                    end
                    EMIT: begin
                        if (pack_ready) begin
                            pack_valid <= 1'b0;
                            if (pack_idx == LAST_IDX) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                pass_cnt <= pass_cnt + CNT_W'(1);
                            end else begin
                                state      <= FIRE;
                                pack_idx   <= pack_idx + IW'(1);
                                pack_start <= N_PACKS'(1) << (pack_idx + IW'(1));
                            end
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        pack_idx <= '0;
                    end
                    default: begin
                        state      <= IDLE;
                        pack_idx   <= '0;
                        pack_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire
